// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 keyboard receiver:
//               receiver state encoding, set-2 scan codes, HID key codes and
//               the scan-code to HID lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Frame receiver states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // Set-2 make codes of the keys the game cares about
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // HID usage codes presented to the game logic
    localparam logic [7:0] KEY_W     = 8'd26;
    localparam logic [7:0] KEY_A     = 8'd4;
    localparam logic [7:0] KEY_S     = 8'd22;
    localparam logic [7:0] KEY_D     = 8'd7;
    localparam logic [7:0] KEY_SPACE = 8'd44;
    localparam logic [7:0] KEY_NONE  = 8'd0;

    // Translate a set-2 code to HID; KEY_NONE marks an unmapped key
    function automatic logic [7:0] map_key(input logic [7:0] sc);
        logic [7:0] hid;
        hid = KEY_NONE;
        case (sc)
            SC_W:     hid = KEY_W;
            SC_A:     hid = KEY_A;
            SC_S:     hid = KEY_S;
            SC_D:     hid = KEY_D;
            SC_SPACE: hid = KEY_SPACE;
            default:  hid = KEY_NONE;
        endcase
        return hid;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx
// Description : PS/2 frame receiver. Synchronizes the raw pins, detects
//               falling clock edges, assembles 11-bit frames (start, 8 data
//               LSB first, odd parity, stop) and guards against stalled
//               frames with a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int         c_wd_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_wd_w-1:0] c_wd_max = c_wd_w'(TIMEOUT_CYCLES - 1);

    logic r_clk_s1, r_clk_s2, r_clk_prev;
    logic r_dat_s1, r_dat_s2, r_dat_d;
    logic r_fall;

    rx_state_t   r_state, w_state_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_par, w_par_nxt;
    logic [c_wd_w-1:0] r_wd;
    logic        w_wd_expire;
    logic        w_bv, w_fe;
    logic [7:0]  r_byte;
    logic        r_byte_valid, r_frame_err;

    // Two-flop synchronizers and registered falling-edge detect; data is
    // delayed one stage so it stays aligned with r_fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_dat_d    <= 1'b1;
            r_fall     <= 1'b0;
        end else begin
            r_clk_s1   <= i_ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= i_ps2_data;
            r_dat_s2   <= r_dat_s1;
            r_dat_d    <= r_dat_s2;
            r_fall     <= r_clk_prev & ~r_clk_s2;
        end
    end

    assign w_wd_expire = (r_state != IDLE) && (r_wd == c_wd_max);

    // Watchdog: counts cycles spent mid-frame, restarted by every edge
    always_ff @(posedge clk) begin
        if (rst || r_state == IDLE || r_fall || w_wd_expire) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + 1'b1;
        end
    end

    // Frame FSM next-state logic; an expiring watchdog overrides any edge
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_bv        = 1'b0;
        w_fe        = 1'b0;
        if (w_wd_expire) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 3'd0;
            w_shift_nxt = 8'd0;
            w_fe        = 1'b1;
        end else if (r_fall) begin
            case (r_state)
                IDLE: begin
                    if (!r_dat_d) begin
                        w_state_nxt = DATA;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_fe = 1'b1;
                    end
                end
                DATA: begin
                    w_shift_nxt = {r_dat_d, r_shift[7:1]};
                    if (r_cnt == 3'd7) begin
                        w_state_nxt = PARITY;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
                PARITY: begin
                    w_par_nxt   = r_dat_d;
                    w_state_nxt = STOP;
                end
                STOP: begin
                    if (r_dat_d && (^{r_shift, r_par})) begin
                        w_bv = 1'b1;
                    end else begin
                        w_fe = 1'b1;
                    end
                    w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Frame FSM state and registered result pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= 3'd0;
            r_shift      <= 8'd0;
            r_par        <= 1'b0;
            r_byte       <= 8'd0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_par        <= w_par_nxt;
            r_byte_valid <= w_bv;
            r_frame_err  <= w_fe;
            if (w_bv) begin
                r_byte <= r_shift;
            end
        end
    end

    assign o_byte       = r_byte;
    assign o_byte_valid = r_byte_valid;
    assign o_frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keyboard
// Description : PS/2 set-2 keyboard front end. Receives scan-code bytes,
//               tracks make/break/extended prefixes and holds the HID code
//               of the most recently pressed mapped key while it is down.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_event,
    output logic       frame_err
);

    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       w_frame_err;
    logic [7:0] w_hid;
    logic       r_brk, r_ext;
    logic [7:0] r_keycode;
    logic       r_key_event;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk          (Clk),
        .rst          (Reset),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err)
    );

    // Extended codes never map to a game key
    assign w_hid = r_ext ? KEY_NONE : map_key(w_byte);

    // Make/break decoder and held-key register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_brk       <= 1'b0;
            r_ext       <= 1'b0;
            r_keycode   <= KEY_NONE;
            r_key_event <= 1'b0;
        end else begin
            r_key_event <= 1'b0;
            if (w_frame_err) begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end else if (w_byte_valid) begin
                if (w_byte == SC_BREAK) begin
                    r_brk <= 1'b1;
                end else if (w_byte == SC_EXT) begin
                    r_ext <= 1'b1;
                end else begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                    if (w_hid != KEY_NONE) begin
                        if (!r_brk) begin
                            r_keycode   <= w_hid;
                            r_key_event <= (w_hid != r_keycode);
                        end else if (w_hid == r_keycode) begin
                            r_keycode   <= KEY_NONE;
                            r_key_event <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign keycode   = r_keycode;
    assign key_event = r_key_event;
    assign frame_err = w_frame_err;

endmodule
`default_nettype wire

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- Receives PS/2 set-2 scan-code frames from the keyboard and produces the 8-bit USB-HID-style `keycode` consumed by the game state machine.
- Keycode encodings: W=26, A=4, S=22, D=7, Space=44.
- Tracks make/break codes so `keycode` holds the most recently pressed mapped key while that key is down, and 0 when no mapped key is held.
- Sits between the board PS/2 pins and the game control logic.

Parameters:
- TIMEOUT_CYCLES, 50000: Clk cycles without a PS/2 falling edge mid-frame before the frame is abandoned (1 ms at 50 MHz).

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- ps2_clk  input  1  raw PS/2 clock from pin; asynchronous
- ps2_data  input  1  raw PS/2 data from pin; asynchronous
- keycode  output  8  HID code of held mapped key; 0 = none
- key_event  output  1  one-cycle pulse whenever keycode changes value
- frame_err  output  1  one-cycle pulse on start/parity/stop error or timeout

Behaviour:
- Reset values: keycode=0, key_event=0, frame_err=0; receiver in IDLE; prefix flags cleared; synchronizers cleared to 1.
- Reset mid-frame discards the partial frame.

Synchronization and edge detection:
- ps2_clk and ps2_data each pass through a 2-flop synchronizer.
- fall = prev_sync_clk & ~sync_clk, registered.
- Data is sampled only in the cycle where fall=1.

Receiver FSM (ps2_rx):
- IDLE: on fall with data=0 -> DATA with bit count 0. On fall with data=1 -> stay in IDLE and pulse frame_err.
- DATA: shift bits in LSB first. After the 8th bit -> PARITY.
- PARITY: capture the parity bit -> STOP.
- STOP: on fall, if data=1 and odd parity over 8 data bits + parity bit holds, pulse byte_valid with the byte on the following cycle; otherwise pulse frame_err. In both cases -> IDLE.
- Watchdog: counts Clk cycles in any non-IDLE state and clears on each fall. When the count reaches TIMEOUT_CYCLES-1: -> IDLE, pulse frame_err, discard bits, clear prefix flags.
- Any frame_err also clears the prefix flags.

Decoder (on byte_valid):
- 0xF0: set brk flag. 0xE0: set ext flag. Neither changes keycode.
- Any other byte: look it up if ext=0; treat as unmapped if ext=1. Then clear brk and ext.
- Set-2 -> HID mapping: 0x1D->26, 0x1C->4, 0x1B->22, 0x23->7, 0x29->44. All others are unmapped.
- Make of a mapped key: keycode <= mapped value. Key repeat with the same value does not pulse key_event.
- Break of a mapped key equal to the current keycode: keycode <= 0.
- Break of a mapped key not currently held: no change.
- Unmapped make or break: no change.

Latency:
- Let E be the cycle the registered fall that samples the stop bit is high.
- byte_valid occurs at E+1.
- keycode updates and key_event pulses at E+2.
- frame_err pulses at E+1 for a stop/parity error.

Simultaneous events:
- A fall arriving in the same cycle the watchdog expires: the watchdog wins and the edge is ignored.

Decomposition:
- ps2_pkg holds:
  - the rx state enum {IDLE, DATA, PARITY, STOP}
  - scan-code constants SC_W/SC_A/SC_S/SC_D/SC_SPACE, SC_BREAK=0xF0, SC_EXT=0xE0
  - HID constants KEY_W=26, KEY_A=4, KEY_S=22, KEY_D=7, KEY_SPACE=44
- One sub-module, ps2_rx, contains the synchronizers, edge detect, frame FSM and watchdog, and outputs byte[7:0], byte_valid and frame_err.
- ps2_keyboard instantiates ps2_rx and contains the make/break decoder and keycode register.

Test Plan:
- Send frame 0x1D with correct parity and stop bit -> keycode=26 and one key_event pulse at E+2; frame_err stays 0.
- Send 0x1D, then 0xF0, 0x1D -> keycode returns to 0 with a second key_event; 0xF0 alone causes no change.
- Hold A (0x1C -> keycode=4), then press W (0x1D -> 26), then send break A (0xF0, 0x1C) -> keycode stays 26 and no key_event pulses for the break.
- Send frame 0x1D with a flipped parity bit -> frame_err pulses once, keycode unchanged; a following valid 0x1B -> keycode=22.
- Send start + 4 data bits, then hold ps2_clk high for TIMEOUT_CYCLES -> frame_err pulses once and FSM is in IDLE; a following full 0x23 frame -> keycode=7.
- Send 0xE0, 0x1D -> keycode unchanged. Assert Reset mid-frame, then send 0x29 -> keycode=44, with no stale bits from the discarded frame.
